// File: rtl/mem_ctrl.sv
// Byte-serial RAM/IO bus controller serving IF word reads and LS 1/2/4-byte reads/writes.
// Optional MEM_CTRL_DBG_CNT_EN adds dbg_cnt_o, a running count of completed acks.
module mem_ctrl #(
    parameter int unsigned LAT     = 2,
    parameter logic [1:0]  IO_BASE = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_inst_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [1:0]  ls_len_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_ack_o,
    output logic [31:0] ls_rdata_o,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
`ifdef MEM_CTRL_DBG_CNT_EN
   ,output logic [31:0] dbg_cnt_o
`endif
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t          state_q, state_d;
    logic            is_ls_q, is_ls_d;
    logic [2:0]      n_q, n_d;
    logic [2:0]      nxt_q, nxt_d;
    logic [2:0]      cap_q, cap_d;
    logic [LAT-1:0]  pipe_q, pipe_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     asm_q, asm_d;
    logic [31:0]     mem_a_d;
    logic [7:0]      mem_dout_d;
    logic            wr_q, wr_d;
    logic            if_ack_d, ls_ack_d;
    logic            ls_go, if_go, issue, last_cap;
    logic [2:0]      ls_n;
    logic [31:0]     sel_addr;

    // The client being acked still holds its request during the ack cycle; mask it.
    assign ls_go    = ls_req_i && !ls_ack_o;
    assign if_go    = if_req_i && !if_ack_o;
    assign sel_addr = ls_go ? ls_addr_i : if_addr_i;
    assign issue    = (nxt_q < n_q);
    assign last_cap = pipe_q[LAT-1] && (cap_q + 3'd1 == n_q);

    always_comb begin
        ls_n = ls_len_i[1] ? 3'd4 : (ls_len_i[0] ? 3'd2 : 3'd1);
        if (!ls_we_i && ls_addr_i[17:16] == IO_BASE)
            ls_n = 3'd1;
    end

    assign if_inst_o  = asm_q;
    assign ls_rdata_o = asm_q;
    assign mem_wr     = wr_q && rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rdy) begin
            case (state_q)
                IDLE: if (ls_go)      state_d = ls_we_i ? WR : RD;
                      else if (if_go) state_d = RD;
                RD:   if (last_cap)   state_d = IDLE;
                WR:   if (!issue)     state_d = IDLE;
                default:              state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        is_ls_d    = is_ls_q;
        n_d        = n_q;
        nxt_d      = nxt_q;
        cap_d      = cap_q;
        pipe_d     = pipe_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        mem_a_d    = mem_a;
        mem_dout_d = mem_dout;
        wr_d       = wr_q;
        if_ack_d   = 1'b0;
        ls_ack_d   = 1'b0;
        if (rdy) begin
            case (state_q)
                IDLE: if (ls_go || if_go) begin
                    is_ls_d    = ls_go;
                    n_d        = ls_go ? ls_n : 3'd4;
                    addr_d     = sel_addr;
                    wdata_d    = ls_wdata_i;
                    nxt_d      = 3'd1;
                    cap_d      = '0;
                    asm_d      = '0;
                    mem_a_d    = sel_addr;
                    mem_dout_d = ls_wdata_i[7:0];
                    wr_d       = ls_go && ls_we_i;
                    pipe_d     = '0;
                    pipe_d[0]  = !(ls_go && ls_we_i);
                end
                RD: begin
                    pipe_d = LAT'({pipe_q, issue});
                    if (issue) begin
                        mem_a_d = addr_q + 32'(nxt_q);
                        nxt_d   = nxt_q + 3'd1;
                    end
                    if (pipe_q[LAT-1]) begin
                        asm_d[{cap_q[1:0], 3'b000} +: 8] = mem_din;
                        cap_d = cap_q + 3'd1;
                    end
                    if (last_cap) begin
                        pipe_d   = '0;
                        if_ack_d = !is_ls_q;
                        ls_ack_d = is_ls_q;
                    end
                end
                WR: begin
                    if (issue) begin
                        mem_a_d    = addr_q + 32'(nxt_q);
                        mem_dout_d = wdata_q[{nxt_q[1:0], 3'b000} +: 8];
                        nxt_d      = nxt_q + 3'd1;
                    end else begin
                        wr_d     = 1'b0;
                        ls_ack_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (state_q == RD) begin
            // In-flight bytes are lost while paused: rewind issue to the first uncaptured byte.
            pipe_d = '0;
            nxt_d  = cap_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_ls_q  <= 1'b0;
            n_q      <= '0;
            nxt_q    <= '0;
            cap_q    <= '0;
            pipe_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            asm_q    <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
            wr_q     <= 1'b0;
            if_ack_o <= 1'b0;
            ls_ack_o <= 1'b0;
        end else begin
            is_ls_q  <= is_ls_d;
            n_q      <= n_d;
            nxt_q    <= nxt_d;
            cap_q    <= cap_d;
            pipe_q   <= pipe_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            asm_q    <= asm_d;
            mem_a    <= mem_a_d;
            mem_dout <= mem_dout_d;
            wr_q     <= wr_d;
            if_ack_o <= if_ack_d;
            ls_ack_o <= ls_ack_d;
        end
    end

`ifdef MEM_CTRL_DBG_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                      dbg_cnt_o <= '0;
        else if (if_ack_d || ls_ack_d) dbg_cnt_o <= dbg_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a 2-cycle-latency byte RAM and an I/O byte source.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_inst;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [1:0]  ls_len = '0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
`ifdef MEM_CTRL_DBG_CNT_EN
    logic [31:0] dbg_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] ram [0:4095];

    mem_ctrl #(.LAT(2), .IO_BASE(2'b11)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .if_req_i  (if_req),
        .if_addr_i (if_addr),
        .if_ack_o  (if_ack),
        .if_inst_o (if_inst),
        .ls_req_i  (ls_req),
        .ls_we_i   (ls_we),
        .ls_len_i  (ls_len),
        .ls_addr_i (ls_addr),
        .ls_wdata_i(ls_wdata),
        .ls_ack_o  (ls_ack),
        .ls_rdata_o(ls_rdata),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_a     (mem_a),
        .mem_wr    (mem_wr)
`ifdef MEM_CTRL_DBG_CNT_EN
       ,.dbg_cnt_o (dbg_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Registered-output RAM: byte addressed in cycle t appears on mem_din in cycle t+1.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= (mem_a[17:16] == 2'b11) ? 8'h41 : ram[mem_a[11:0]];
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        tick; tick;
        total++; if (mem_a !== 32'h0)    begin bad++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
        total++; if (mem_dout !== 8'h0)  begin bad++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
        total++; if (mem_wr !== 1'b0)    begin bad++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        total++; if (if_ack !== 1'b0)    begin bad++; $display("FAIL reset_if_ack: got %b want 0", if_ack); end
        total++; if (ls_ack !== 1'b0)    begin bad++; $display("FAIL reset_ls_ack: got %b want 0", ls_ack); end
        total++; if (if_inst !== 32'h0)  begin bad++; $display("FAIL reset_if_inst: got %h want 0", if_inst); end
        total++; if (ls_rdata !== 32'h0) begin bad++; $display("FAIL reset_ls_rdata: got %h want 0", ls_rdata); end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_if_read;
        if_addr = 32'h10; if_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick;
            if (k <= 4) begin
                total++;
                if (mem_a !== 32'h10 + k - 1) begin bad++; $display("FAIL if_rd_addr k=%0d: got %h want %h", k, mem_a, 32'h10 + k - 1); end
            end
            total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL if_rd_wr k=%0d: got %b want 0", k, mem_wr); end
            total++; if (if_ack !== (k == 6)) begin bad++; $display("FAIL if_rd_ack k=%0d: got %b want %b", k, if_ack, k == 6); end
            if (k == 6) begin
                total++; if (if_inst !== 32'h1312_1110) begin bad++; $display("FAIL if_rd_inst: got %h want 13121110", if_inst); end
                if_req = 1'b0;
            end
        end
    endtask

    task automatic test_priority;
        ls_addr = 32'h20; ls_len = 2'b00; ls_we = 1'b0; ls_req = 1'b1;
        if_addr = 32'h10; if_req = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick;
            if (k == 1) begin total++; if (mem_a !== 32'h20) begin bad++; $display("FAIL prio_first_addr: got %h want 20", mem_a); end end
            if (k == 4) begin total++; if (mem_a !== 32'h10) begin bad++; $display("FAIL prio_if_addr: got %h want 10", mem_a); end end
            total++; if (ls_ack !== (k == 3)) begin bad++; $display("FAIL prio_ls_ack k=%0d: got %b want %b", k, ls_ack, k == 3); end
            total++; if (if_ack !== (k == 9)) begin bad++; $display("FAIL prio_if_ack k=%0d: got %b want %b", k, if_ack, k == 9); end
            if (k == 3) begin
                total++; if (ls_rdata !== 32'h0000_00AB) begin bad++; $display("FAIL prio_ls_rdata: got %h want 000000ab", ls_rdata); end
                ls_req = 1'b0;
            end
            if (k == 9) begin
                total++; if (if_inst !== 32'h1312_1110) begin bad++; $display("FAIL prio_if_inst: got %h want 13121110", if_inst); end
                if_req = 1'b0;
            end
        end
    endtask

    task automatic test_write;
        ls_addr = 32'h100; ls_len = 2'b01; ls_we = 1'b1; ls_wdata = 32'hDEAD_BEEF; ls_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick;
            total++; if (mem_wr !== (k <= 2)) begin bad++; $display("FAIL wr_en k=%0d: got %b want %b", k, mem_wr, k <= 2); end
            total++; if (ls_ack !== (k == 3)) begin bad++; $display("FAIL wr_ack k=%0d: got %b want %b", k, ls_ack, k == 3); end
            if (k == 1) begin
                total++; if (mem_a !== 32'h100 || mem_dout !== 8'hEF) begin bad++; $display("FAIL wr_b0: got %h/%h want 100/ef", mem_a, mem_dout); end
            end
            if (k == 2) begin
                total++; if (mem_a !== 32'h101 || mem_dout !== 8'hBE) begin bad++; $display("FAIL wr_b1: got %h/%h want 101/be", mem_a, mem_dout); end
            end
            if (k == 3) ls_req = 1'b0;
        end
        ls_we = 1'b0; ls_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick;
            total++; if (ls_ack !== (k == 4)) begin bad++; $display("FAIL wr_rb_ack k=%0d: got %b want %b", k, ls_ack, k == 4); end
            if (k == 4) begin
                total++; if (ls_rdata !== 32'h0000_BEEF) begin bad++; $display("FAIL wr_rb_data: got %h want 0000beef", ls_rdata); end
                ls_req = 1'b0;
            end
        end
    endtask

    task automatic test_io_read;
        ls_addr = 32'h0003_0000; ls_len = 2'b10; ls_we = 1'b0; ls_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick;
            if (k == 1) begin total++; if (mem_a !== 32'h0003_0000) begin bad++; $display("FAIL io_addr: got %h want 00030000", mem_a); end end
            total++; if (mem_a inside {32'h0003_0001, 32'h0003_0002, 32'h0003_0003}) begin bad++; $display("FAIL io_overread k=%0d: got %h want 00030000", k, mem_a); end
            total++; if (ls_ack !== (k == 3)) begin bad++; $display("FAIL io_ack k=%0d: got %b want %b", k, ls_ack, k == 3); end
            if (k == 3) begin
                total++; if (ls_rdata !== 32'h0000_0041) begin bad++; $display("FAIL io_rdata: got %h want 00000041", ls_rdata); end
                ls_req = 1'b0;
            end
        end
    endtask

    task automatic test_pause;
        int acks = 0;
        int ack_k = 0;
        if_addr = 32'h10; if_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick;
            if (k >= 4 && k <= 6) begin
                total++; if (if_ack !== 1'b0) begin bad++; $display("FAIL pause_ack_low k=%0d: got %b want 0", k, if_ack); end
                total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL pause_wr k=%0d: got %b want 0", k, mem_wr); end
            end
            if (if_ack === 1'b1) begin
                acks++; ack_k = k;
                total++; if (if_inst !== 32'h1312_1110) begin bad++; $display("FAIL pause_inst: got %h want 13121110", if_inst); end
                if_req = 1'b0;
            end
            if (k == 3) rdy = 1'b0;
            if (k == 6) rdy = 1'b1;
        end
        if_req = 1'b0;
        total++; if (acks != 1) begin bad++; $display("FAIL pause_ack_count: got %0d want 1", acks); end
        total++; if (ack_k < 9) begin bad++; $display("FAIL pause_ack_delay: got cycle A+%0d want >= A+9", ack_k); end
    endtask

    task automatic test_reset_mid;
        ls_addr = 32'h200; ls_len = 2'b10; ls_we = 1'b1; ls_wdata = 32'h4433_2211; ls_req = 1'b1;
        tick;
        total++; if (mem_wr !== 1'b1 || mem_a !== 32'h200) begin bad++; $display("FAIL rstmid_b0: got %b/%h want 1/200", mem_wr, mem_a); end
        tick;
        total++; if (mem_wr !== 1'b1 || mem_a !== 32'h201) begin bad++; $display("FAIL rstmid_b1: got %b/%h want 1/201", mem_wr, mem_a); end
        rst = 1'b0;
        #1;
        total++; if (mem_wr !== 1'b0) begin bad++; $display("FAIL rstmid_wr: got %b want 0", mem_wr); end
        total++; if (mem_a !== 32'h0) begin bad++; $display("FAIL rstmid_addr: got %h want 0", mem_a); end
        total++; if (mem_dout !== 8'h0) begin bad++; $display("FAIL rstmid_dout: got %h want 0", mem_dout); end
        ls_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick;
            total++; if (ls_ack !== 1'b0) begin bad++; $display("FAIL rstmid_noack k=%0d: got %b want 0", k, ls_ack); end
        end
        rst = 1'b1;
        tick;
        total++; if (ls_ack !== 1'b0) begin bad++; $display("FAIL rstmid_noack_rel: got %b want 0", ls_ack); end
        ls_we = 1'b0; ls_len = 2'b01; ls_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick;
            total++; if (ls_ack !== (k == 4)) begin bad++; $display("FAIL rstmid_rb_ack k=%0d: got %b want %b", k, ls_ack, k == 4); end
            if (k == 4) begin
                total++; if (ls_rdata !== 32'h0000_5A11) begin bad++; $display("FAIL rstmid_rb_data: got %h want 00005a11", ls_rdata); end
                ls_req = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h010] = 8'h10; ram[12'h011] = 8'h11; ram[12'h012] = 8'h12; ram[12'h013] = 8'h13;
        ram[12'h020] = 8'hAB;
        ram[12'h102] = 8'h77;
        ram[12'h201] = 8'h5A;

        test_reset;
        test_if_read;
        tick;
        test_priority;
        tick;
        test_write;
        tick;
        test_io_read;
        tick;
        test_pause;
        tick;
        test_reset_mid;
`ifdef MEM_CTRL_DBG_CNT_EN
        total++; if (dbg_cnt !== 32'd1) begin bad++; $display("FAIL dbg_cnt: got %0d want 1", dbg_cnt); end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
